// File: rtl/cpu_trace_monitor.sv
// Commit-trace capture buffer and run-control FSM for the single-cycle CPU.
// Optional build macro TRACE_FILTER_EN: capture only cycles that write a nonzero RF register.
module cpu_trace_monitor #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 16,
  parameter logic [XLEN-1:0] STOP_PC    = 'h48,
  parameter int              MAX_CYCLES = 1000,
  parameter int              CNT_W      = 16,
  parameter bit              WRAP       = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [XLEN-1:0]            pc_in,
  input  logic [31:0]                instr_in,
  input  logic                       rf_we,
  input  logic [4:0]                 rf_waddr,
  input  logic [XLEN-1:0]            rf_wdata,
  input  logic                       rd_en,
  output logic [2*XLEN+37:0]         rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       running,
  output logic                       halt,
  output logic [1:0]                 halt_cause,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * XLEN + 38;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cycle_cnt_reg;
  logic [1:0]       cause_reg;
  logic             overflow_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [EW-1:0]    rd_data_reg;
  logic             rd_valid_reg;
  logic [EW-1:0]    mem [DEPTH];

  logic             in_run;
  logic             pc_hit;
  logic             limit_hit;
  logic [1:0]       evt_cause;
  logic             run_cycle;
  logic             filter_pass;
  logic             start_go;
  logic             push;
  logic             pop;
  logic             buf_empty;
  logic             buf_full;
  logic             do_write;
  logic             drop_oldest;
  logic [EW-1:0]    entry;

  // ---------------------------------------------------------------- event decode
  assign in_run   = (state_reg == S_RUN);
  assign pc_hit   = (pc_in == STOP_PC);
  assign start_go = start && (state_reg != S_RUN);

  generate
    if (MAX_CYCLES > 0) begin : g_limit
      localparam logic [31:0] LIMIT_LAST = 32'(MAX_CYCLES - 1);
      assign limit_hit = (32'(cycle_cnt_reg) == LIMIT_LAST);
    end else begin : g_no_limit
      assign limit_hit = 1'b0;
    end
  endgenerate

  // Halt source priority: stop PC, then cycle budget, then external stop.
  always_comb begin
    evt_cause = 2'd0;
    if (in_run) begin
      if (pc_hit) begin
        evt_cause = 2'd1;
      end else if (limit_hit) begin
        evt_cause = 2'd2;
      end else if (stop) begin
        evt_cause = 2'd3;
      end
    end
  end

  // An external stop that wins arbitration suppresses that cycle entirely.
  assign run_cycle = in_run && (evt_cause != 2'd3);

`ifdef TRACE_FILTER_EN
  assign filter_pass = rf_we && (rf_waddr != 5'd0);
`else
  assign filter_pass = 1'b1;
`endif

  assign push  = run_cycle && filter_pass;
  assign entry = {pc_in, instr_in, rf_we, rf_waddr, rf_wdata};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_RUN;
      S_RUN:    if (evt_cause != 2'd0) state_next = S_HALTED;
      S_HALTED: if (start) state_next = S_RUN;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    running = (state_reg == S_RUN);
    halt    = (state_reg == S_HALTED);
  end

  // ---------------------------------------------------------------- run statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_reg <= '0;
      cause_reg     <= 2'd0;
    end else if (start_go) begin
      cycle_cnt_reg <= '0;
      cause_reg     <= 2'd0;
    end else begin
      if (run_cycle && (cycle_cnt_reg != '1)) begin
        cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      end
      if (evt_cause != 2'd0) begin
        cause_reg <= evt_cause;
      end
    end
  end

  // ---------------------------------------------------------------- trace buffer
  assign buf_empty = (count_reg == '0);
  assign buf_full  = (count_reg == CW'(DEPTH));
  assign pop       = rd_en && !buf_empty;

  // A pop in the same cycle frees a slot, so a full buffer can still accept the push.
  assign do_write    = push && (!buf_full || pop || WRAP);
  assign drop_oldest = push && buf_full && !pop && WRAP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= pop;
      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop || drop_oldest) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (do_write && !pop && !buf_full) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !do_write) begin
        count_reg <= count_reg - 1'b1;
      end
      if (start_go) begin
        overflow_reg <= 1'b0;
      end else if (push && buf_full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg] <= entry;
    end
  end

  // Registered read; on a full push+pop the old slot contents are returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (pop) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  // ---------------------------------------------------------------- outputs
  assign rd_data    = rd_data_reg;
  assign rd_valid   = rd_valid_reg;
  assign empty      = buf_empty;
  assign full       = buf_full;
  assign count      = count_reg;
  assign halt_cause = cause_reg;
  assign cycle_cnt  = cycle_cnt_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Bench for cpu_trace_monitor: three configurations driven in lockstep against a queue-style reference model.
module tb_cpu_trace_monitor;

  localparam int XLEN = 32;
  localparam int EW   = 2 * XLEN + 38;
  localparam logic [31:0] STOP = 32'h48;

  typedef logic [EW-1:0] entry_t;

  logic        clk = 1'b0;
  logic        rst, start, stop, rf_we, rd_en;
  logic [31:0] pc_in, instr_in, rf_wdata;
  logic [4:0]  rf_waddr;

  entry_t      rd_data    [3];
  logic        rd_valid   [3];
  logic        empty      [3];
  logic        full       [3];
  logic        running    [3];
  logic        halt       [3];
  logic        overflow   [3];
  logic [1:0]  halt_cause [3];
  logic [15:0] cycle_cnt  [3];
  logic [5:0]  count_a;
  logic [2:0]  count_b;
  logic [2:0]  count_c;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int     dep  [3];
  bit     wrp  [3];
  int     maxc [3];
  int     m_st [3];
  int     m_cyc[3];
  int     m_cause[3];
  bit     m_ovf[3];
  entry_t m_buf[3][32];
  int     m_head[3];
  int     m_size[3];
  entry_t m_rd [3];
  bit     m_rv [3];

  always #5 clk = ~clk;

  cpu_trace_monitor #(.XLEN(32), .DEPTH(32), .STOP_PC(32'h48), .MAX_CYCLES(1000), .CNT_W(16), .WRAP(1'b1)) u_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pc_in(pc_in), .instr_in(instr_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_en(rd_en),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .empty(empty[0]), .full(full[0]), .count(count_a),
    .running(running[0]), .halt(halt[0]), .halt_cause(halt_cause[0]), .cycle_cnt(cycle_cnt[0]),
    .overflow(overflow[0]));

  cpu_trace_monitor #(.XLEN(32), .DEPTH(4), .STOP_PC(32'h48), .MAX_CYCLES(10), .CNT_W(16), .WRAP(1'b1)) u_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pc_in(pc_in), .instr_in(instr_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_en(rd_en),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .empty(empty[1]), .full(full[1]), .count(count_b),
    .running(running[1]), .halt(halt[1]), .halt_cause(halt_cause[1]), .cycle_cnt(cycle_cnt[1]),
    .overflow(overflow[1]));

  cpu_trace_monitor #(.XLEN(32), .DEPTH(4), .STOP_PC(32'h48), .MAX_CYCLES(10), .CNT_W(16), .WRAP(1'b0)) u_c (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pc_in(pc_in), .instr_in(instr_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_en(rd_en),
    .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .empty(empty[2]), .full(full[2]), .count(count_c),
    .running(running[2]), .halt(halt[2]), .halt_cause(halt_cause[2]), .cycle_cnt(cycle_cnt[2]),
    .overflow(overflow[2]));

  function automatic int dut_count(input int k);
    case (k)
      0:       return int'(count_a);
      1:       return int'(count_b);
      default: return int'(count_c);
    endcase
  endfunction

  function automatic logic [31:0] pc_of(input entry_t e);
    return e[EW-1 -: 32];
  endfunction

  function automatic bit filt();
`ifdef TRACE_FILTER_EN
    return rf_we && (rf_waddr != 5'd0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_cyc[k] = 0; m_cause[k] = 0; m_ovf[k] = 1'b0;
      m_head[k] = 0; m_size[k] = 0; m_rd[k] = '0; m_rv[k] = 1'b0;
    end
  endtask

  // One clock of behaviour: run control first, then the buffer as pop-front / push-back.
  task automatic model_step(input int k);
    entry_t e;
    bit     pop;
    bit     push;
    int     cause;
    e     = {pc_in, instr_in, rf_we, rf_waddr, rf_wdata};
    pop   = rd_en && (m_size[k] > 0);
    push  = 1'b0;
    cause = 0;
    if (m_st[k] == 1) begin
      if (pc_in == STOP) cause = 1;
      else if (maxc[k] != 0 && m_cyc[k] == maxc[k] - 1) cause = 2;
      else if (stop) cause = 3;
      if (cause != 3) begin
        push = filt();
        if (m_cyc[k] < 65535) m_cyc[k]++;
      end
      if (cause != 0) begin
        m_st[k] = 2;
        m_cause[k] = cause;
      end
    end else if (start) begin
      m_st[k] = 1; m_cyc[k] = 0; m_cause[k] = 0; m_ovf[k] = 1'b0;
    end
    m_rv[k] = pop;
    if (pop) begin
      m_rd[k]   = m_buf[k][m_head[k]];
      m_head[k] = (m_head[k] + 1) % dep[k];
      m_size[k]--;
    end
    if (push) begin
      if (m_size[k] == dep[k]) begin
        m_ovf[k] = 1'b1;
        if (wrp[k]) begin
          m_head[k] = (m_head[k] + 1) % dep[k];
          m_size[k]--;
        end
      end
      if (m_size[k] < dep[k]) begin
        m_buf[k][(m_head[k] + m_size[k]) % dep[k]] = e;
        m_size[k]++;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.running", k),    128'(running[k]),    128'(m_st[k] == 1));
      chk($sformatf("u%0d.halt", k),       128'(halt[k]),       128'(m_st[k] == 2));
      chk($sformatf("u%0d.halt_cause", k), 128'(halt_cause[k]), 128'(m_cause[k]));
      chk($sformatf("u%0d.cycle_cnt", k),  128'(cycle_cnt[k]),  128'(m_cyc[k]));
      chk($sformatf("u%0d.count", k),      128'(dut_count(k)),  128'(m_size[k]));
      chk($sformatf("u%0d.empty", k),      128'(empty[k]),      128'(m_size[k] == 0));
      chk($sformatf("u%0d.full", k),       128'(full[k]),       128'(m_size[k] == dep[k]));
      chk($sformatf("u%0d.overflow", k),   128'(overflow[k]),   128'(m_ovf[k]));
      chk($sformatf("u%0d.rd_valid", k),   128'(rd_valid[k]),   128'(m_rv[k]));
      chk($sformatf("u%0d.rd_data", k),    128'(rd_data[k]),    128'(m_rd[k]));
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else for (int k = 0; k < 3; k++) model_step(k);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic drive_pc(input logic [31:0] pc);
    pc_in    = pc;
    instr_in = $urandom;
    rf_wdata = $urandom;
    rf_we    = 1'b1;
    rf_waddr = 5'd5;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; drive_pc(32'h100); tick(); stop = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    dep  = '{32, 4, 4};
    wrp  = '{1'b1, 1'b1, 1'b0};
    maxc = '{1000, 10, 10};
    rst = 1'b1; start = 1'b0; stop = 1'b0; rd_en = 1'b0;
    pc_in = '0; instr_in = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    model_reset();
    @(negedge clk);
    tick();
    chk("reset.empty", 128'(empty[0]), 128'(1));
    chk("reset.count", 128'(count_a), 128'(0));
    rst = 1'b0;

    // Run to the stop PC: 19 commits 0x00..0x48
    pulse_start();
    for (int i = 0; i < 19; i++) begin
      drive_pc(32'(4 * i));
      tick();
    end
    drive_pc(32'h200);
    chk("stoppc.halt",  128'(halt[0]), 128'(1));
    chk("stoppc.cause", 128'(halt_cause[0]), 128'(1));
    chk("stoppc.count", 128'(count_a), 128'(19));
    chk("stoppc.cyc",   128'(cycle_cnt[0]), 128'(19));
    chk("limit.cause",  128'(halt_cause[1]), 128'(2));
    chk("limit.cyc",    128'(cycle_cnt[1]), 128'(10));
    rd_en = 1'b1;
    for (int i = 0; i < 19; i++) tick();
    rd_en = 1'b0;
    chk("stoppc.last_pc", 128'(pc_of(rd_data[0])), 128'(32'h48));
    chk("limit.wrap_last_pc", 128'(pc_of(rd_data[1])), 128'(32'h24));
    chk("limit.drop_last_pc", 128'(pc_of(rd_data[2])), 128'(32'h0C));

    // Six captures into DEPTH=4, then external stop
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      drive_pc(32'(4 * i));
      tick();
    end
    pulse_stop();
    chk("wrap.full",  128'(full[1]), 128'(1));
    chk("wrap.ovf",   128'(overflow[1]), 128'(1));
    chk("drop.ovf",   128'(overflow[2]), 128'(1));
    chk("ext.cause",  128'(halt_cause[0]), 128'(3));
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrap.pop_pc", 128'(pc_of(rd_data[1])), 128'(32'(8 + 4 * i)));
      chk("drop.pop_pc", 128'(pc_of(rd_data[2])), 128'(32'(4 * i)));
    end
    chk("wrap.empty", 128'(empty[1]), 128'(1));
    tick(); tick();
    rd_en = 1'b0;

    // Full buffer, push and pop together
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      drive_pc(32'(32'h20 + 4 * i));
      tick();
    end
    chk("pp.pre_ovf", 128'(overflow[1]), 128'(0));
    drive_pc(32'h30);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pp.count",   128'(count_b), 128'(4));
    chk("pp.ovf",     128'(overflow[1]), 128'(0));
    chk("pp.pc",      128'(pc_of(rd_data[1])), 128'(32'h20));
    chk("pp.c_count", 128'(count_c), 128'(4));
    pulse_stop();
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rd_en = 1'b0;
    chk("empty_pop.valid", 128'(rd_valid[1]), 128'(0));
    chk("drop.last_pc", 128'(pc_of(rd_data[2])), 128'(32'h30));

    // Asynchronous reset in the fifth RUN cycle
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      drive_pc(32'(4 * i));
      tick();
    end
    drive_pc(32'h10);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst.running", 128'(running[0]), 128'(0));
    chk("arst.empty",   128'(empty[0]), 128'(1));
    chk("arst.count",   128'(count_a), 128'(0));
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Capture filter: only some cycles write a nonzero register
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      drive_pc(32'(4 * i));
      rf_we    = (i % 3) != 1;
      rf_waddr = (i % 2 == 0) ? 5'd0 : 5'(i);
      tick();
    end
    pulse_stop();
`ifdef TRACE_FILTER_EN
    exp_cnt = 2;
`else
    exp_cnt = 6;
`endif
    chk("filter.count", 128'(count_a), 128'(exp_cnt));
    chk("filter.cyc",   128'(cycle_cnt[0]), 128'(6));

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 29) == 0);
      rd_en    = ($urandom_range(0, 2) == 0);
      pc_in    = 32'($urandom_range(0, 23) * 4);
      instr_in = $urandom;
      rf_wdata = $urandom;
      rf_we    = $urandom_range(0, 1) == 1;
      rf_waddr = 5'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; rd_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
